mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arbiter_arb_pick.sv | 35 +++
 rtl/mem_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF     = 32;
    localparam int DATA_W_DEF     = 32;
    localparam int STARVE_MAX_DEF = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    // Starvation counter must be able to hold STARVE_MAX itself.
    function automatic int starve_w(input int max_cnt);
        return (max_cnt < 1) ? 1 : $clog2(max_cnt + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Winner selection between fetch and data ports, plus next starvation count.
module arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int CNT_W      = starve_w(STARVE_MAX)
) (
    input  logic             i_if_req,
    input  logic             i_dm_req,
    input  logic [CNT_W-1:0] i_starve_cnt,
    output logic             o_any_req,
    output logic             o_win_dm,
    output logic [CNT_W-1:0] o_starve_nxt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic w_starved;

    assign w_starved = (i_starve_cnt >= CNT_MAX);

    always_comb begin
        o_any_req    = i_if_req | i_dm_req;
        o_win_dm     = i_dm_req && !(i_if_req && w_starved);
        o_starve_nxt = i_starve_cnt;
        if (o_any_req) begin
            if (!o_win_dm) begin
                o_starve_nxt = '0;
            end else if (i_if_req && !w_starved) begin
                o_starve_nxt = i_starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: fetch and data share one memory; one transaction in
// flight at a time, IDLE -> ISSUE -> RESP.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = starve_w(STARVE_MAX);

    state_t            r_state;
    owner_t            r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [CNT_W-1:0]  r_starve_cnt;
    logic              r_if_rvalid;
    logic              r_dm_rvalid;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;

    logic              w_any;
    logic              w_win_dm;
    logic              w_grant;
    logic [CNT_W-1:0]  w_starve_nxt;

    arb_pick #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_pick (
        .i_if_req     (if_req),
        .i_dm_req     (dm_req),
        .i_starve_cnt (r_starve_cnt),
        .o_any_req    (w_any),
        .o_win_dm     (w_win_dm),
        .o_starve_nxt (w_starve_nxt)
    );

    // Grant is combinational so mem_req can rise on the very next cycle.
    assign w_grant   = (r_state == IDLE) && w_any && !reset;
    assign if_gnt    = w_grant && !w_win_dm;
    assign dm_gnt    = w_grant && w_win_dm;
    assign mem_req   = (r_state == ISSUE);
    assign mem_we    = mem_req && r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign if_rvalid = r_if_rvalid;
    assign dm_rvalid = r_dm_rvalid;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign busy      = (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_owner      <= OWN_IF;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_starve_cnt <= '0;
            r_if_rvalid  <= 1'b0;
            r_dm_rvalid  <= 1'b0;
            r_if_rdata   <= '0;
            r_dm_rdata   <= '0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_dm_rvalid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state      <= ISSUE;
                        r_starve_cnt <= w_starve_nxt;
                        if (w_win_dm) begin
                            r_owner <= OWN_DM;
                            r_we    <= dm_we;
                            r_addr  <= dm_addr;
                            r_wdata <= dm_wdata;
                        end else begin
                            r_owner <= OWN_IF;
                            r_we    <= 1'b0;
                            r_addr  <= if_addr;
                            r_wdata <= '0;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_ack) begin
                        r_state <= RESP;
                        if (r_owner == OWN_IF) begin
                            r_if_rvalid <= 1'b1;
                            r_if_rdata  <= mem_rdata;
                        end else begin
                            r_dm_rvalid <= 1'b1;
                            r_dm_rdata  <= r_we ? '0 : mem_rdata;
                        end
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter with a scoreboard and memory responder.
module tb_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SMAX = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, dm_req, dm_we;
    logic [AW-1:0] if_addr, dm_addr, mem_addr;
    logic [DW-1:0] dm_wdata, if_rdata, dm_rdata, mem_wdata, mem_rdata;
    logic          if_gnt, if_rvalid, dm_gnt, dm_rvalid;
    logic          mem_req, mem_we, mem_ack, busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
    );

    task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory contents are a fixed scramble of the address unless a directed value is forced.
    int            ack_lat   = -1;
    bit            hold_ack  = 1'b0;
    bit            stray_ack = 1'b0;
    bit            force_en  = 1'b0;
    logic [DW-1:0] force_val = '0;

    function automatic logic [DW-1:0] rdata_for(input logic [AW-1:0] a);
        return force_en ? force_val : (32'(a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F);
    endfunction

    initial begin
        int  wait_cnt;
        bit  ack_sent;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        wait_cnt  = 0;
        ack_sent  = 1'b0;
        forever begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (stray_ack) begin
                stray_ack = 1'b0;
                mem_ack   = 1'b1;
                mem_rdata = 32'hBAD0_0BAD;
            end else if (mem_req && !hold_ack && !ack_sent) begin
                if (wait_cnt == 0) begin
                    mem_ack   = 1'b1;
                    ack_sent  = 1'b1;
                    mem_rdata = rdata_for(mem_addr);
                end else begin
                    wait_cnt--;
                end
            end
            if (!mem_req) begin
                ack_sent = 1'b0;
                wait_cnt = (ack_lat < 0) ? int'($urandom_range(0, 3)) : ack_lat;
            end
        end
    end

    // Scoreboard: expectations are formed at grant time from the bench's own requests.
    bit            in_flight = 1'b0;
    int            sc        = 0;
    bit            gnt_q = 1'b0, ack_q = 1'b0, mreq_q = 1'b0;
    bit            exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    logic [DW-1:0] exp_if_q[$];
    logic [DW-1:0] exp_dm_q[$];
    bit            gnt_log[$];
    int            last_gnt_cyc = 0, last_rv_cyc = 0;

    always @(negedge clk) begin
        bit g, want, win_dm;
        if (reset) begin
            in_flight = 1'b0;
            sc        = 0;
            exp_if_q.delete();
            exp_dm_q.delete();
            gnt_q  = 1'b0;
            ack_q  = 1'b0;
            mreq_q = 1'b0;
        end else begin
            g    = if_gnt | dm_gnt;
            want = !in_flight && (if_req || dm_req);
            chk_eq("busy", busy, in_flight);
            chk_eq("gnt_onehot", (if_gnt && dm_gnt), 0);
            chk_eq("gnt_when_pending", g, want);
            if (g && want) begin
                win_dm = dm_req && !(if_req && sc >= SMAX);
                chk_eq("winner_is_dm", dm_gnt, win_dm);
                gnt_log.push_back(dm_gnt);
                last_gnt_cyc = cyc;
                if (win_dm) begin
                    exp_we    = dm_we;
                    exp_addr  = dm_addr;
                    exp_wdata = dm_wdata;
                    exp_dm_q.push_back(dm_we ? '0 : rdata_for(dm_addr));
                    if (if_req && sc < SMAX) sc++;
                end else begin
                    exp_we   = 1'b0;
                    exp_addr = if_addr;
                    exp_if_q.push_back(rdata_for(if_addr));
                    sc = 0;
                end
                in_flight = 1'b1;
            end
            if (gnt_q) chk_eq("mem_req_after_gnt", mem_req, 1);
            if (mem_req) begin
                if (!mreq_q) chk_eq("mem_req_rise_needs_gnt", gnt_q, 1);
                chk_eq("mem_we", mem_we, exp_we);
                chk_eq("mem_addr", mem_addr, exp_addr);
                if (exp_we) chk_eq("mem_wdata", mem_wdata, exp_wdata);
            end
            if (if_rvalid) begin
                chk_eq("if_rvalid_after_ack", ack_q, 1);
                chk_eq("if_rvalid_expected", exp_if_q.size() > 0, 1);
                if (exp_if_q.size() > 0) chk_eq("if_rdata", if_rdata, exp_if_q.pop_front());
                in_flight   = 1'b0;
                last_rv_cyc = cyc;
            end
            if (dm_rvalid) begin
                chk_eq("dm_rvalid_after_ack", ack_q, 1);
                chk_eq("dm_rvalid_expected", exp_dm_q.size() > 0, 1);
                if (exp_dm_q.size() > 0) chk_eq("dm_rdata", dm_rdata, exp_dm_q.pop_front());
                in_flight   = 1'b0;
                last_rv_cyc = cyc;
            end
            gnt_q  = g;
            ack_q  = mem_ack && mem_req;
            mreq_q = mem_req;
        end
    end

    // Requester: present a request, hold it until granted, then release (scrambling the fields).
    task automatic do_req(input bit is_dm, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        if (is_dm) begin
            dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = d;
        end else begin
            if_req = 1'b1; if_addr = a;
        end
        @(negedge clk);
        while (!(is_dm ? dm_gnt : if_gnt) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk_eq(is_dm ? "dm_gnt_timeout" : "if_gnt_timeout", 0, 1);
        @(posedge clk); #1;
        if (is_dm) begin
            dm_req = 1'b0; dm_we = $urandom_range(0, 1); dm_addr = $urandom; dm_wdata = $urandom;
        end else begin
            if_req = 1'b0; if_addr = $urandom;
        end
    endtask

    task automatic stream(input bit is_dm, input int cnt);
        for (int i = 0; i < cnt; i++)
            do_req(is_dm, is_dm ? bit'($urandom_range(0, 1)) : 1'b0, $urandom & 32'hFFFC, $urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk_eq("idle_reached", n < 100, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp_order[6];
        reset = 1'b1;
        if_req = 1'b1; dm_req = 1'b0; dm_we = 1'b0;
        if_addr = 32'h40; dm_addr = '0; dm_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_eq("rst_if_gnt", if_gnt, 0);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_mem_req", mem_req, 0);
        chk_eq("rst_mem_we", mem_we, 0);
        chk_eq("rst_mem_addr", mem_addr, 0);
        chk_eq("rst_mem_wdata", mem_wdata, 0);
        chk_eq("rst_if_rvalid", if_rvalid, 0);
        chk_eq("rst_dm_rvalid", dm_rvalid, 0);
        chk_eq("rst_if_rdata", if_rdata, 0);
        chk_eq("rst_dm_rdata", dm_rdata, 0);
        @(posedge clk); #1;
        if_req = 1'b0;
        reset  = 1'b0;

        // Single fetch, ack two cycles after mem_req.
        ack_lat = 2; force_en = 1'b1; force_val = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        do_req(1'b0, 1'b0, 32'h10, '0);
        wait_idle();
        chk_eq("fetch_rdata_hold", if_rdata, 32'hDEAD_BEEF);
        chk_eq("fetch_gnt_to_rvalid", last_rv_cyc - last_gnt_cyc, 4);

        // Simultaneous fetch and data write with starve count at zero.
        force_en = 1'b0; ack_lat = 1;
        gnt_log.delete();
        @(posedge clk); #1;
        fork
            do_req(1'b0, 1'b0, 32'h44, '0);
            do_req(1'b1, 1'b1, 32'h20, 32'h5);
        join
        wait_idle();
        chk_eq("simul_grants", gnt_log.size(), 2);
        if (gnt_log.size() == 2) begin
            chk_eq("simul_first_dm", gnt_log[0], 1);
            chk_eq("simul_second_if", gnt_log[1], 0);
        end

        // Both requesters continuously pending.
        gnt_log.delete();
        ack_lat = -1;
        fork
            stream(1'b1, 4);
            stream(1'b0, 2);
        join
        wait_idle();
        exp_order = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        chk_eq("starve_grants", gnt_log.size(), 6);
        for (int i = 0; i < 6 && i < gnt_log.size(); i++)
            chk_eq($sformatf("starve_order_%0d", i), gnt_log[i], exp_order[i]);

        // Reset while the memory request is outstanding.
        hold_ack = 1'b1;
        @(posedge clk); #1;
        do_req(1'b1, 1'b0, 32'h30, '0);
        chk_eq("mid_issue_mem_req", mem_req, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset    = 1'b0;
        hold_ack = 1'b0;
        @(negedge clk);
        chk_eq("post_rst_mem_req", mem_req, 0);
        chk_eq("post_rst_busy", busy, 0);
        chk_eq("post_rst_if_rdata", if_rdata, 0);
        chk_eq("post_rst_dm_rdata", dm_rdata, 0);
        @(posedge clk); #1;
        stray_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_eq("late_ack_if_rvalid", if_rvalid, 0);
            chk_eq("late_ack_dm_rvalid", dm_rvalid, 0);
            chk_eq("late_ack_busy", busy, 0);
        end

        // Stray ack while idle.
        @(posedge clk); #1;
        stray_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_eq("stray_ack_rvalid", if_rvalid | dm_rvalid, 0);
            chk_eq("stray_ack_busy", busy, 0);
        end
        @(posedge clk); #1;

        // Random mix of single, simultaneous and streamed traffic.
        for (int t = 0; t < 30; t++) begin
            case ($urandom_range(0, 3))
                0: do_req(1'b0, 1'b0, $urandom & 32'hFFFC, '0);
                1: do_req(1'b1, bit'($urandom_range(0, 1)), $urandom & 32'hFFFC, $urandom);
                2: fork
                       do_req(1'b0, 1'b0, $urandom & 32'hFFFC, '0);
                       do_req(1'b1, bit'($urandom_range(0, 1)), $urandom & 32'hFFFC, $urandom);
                   join
                default: fork
                       stream(1'b1, $urandom_range(1, 4));
                       stream(1'b0, $urandom_range(1, 3));
                   join
            endcase
            wait_idle();
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
